request_tagger: RTL and testbench
=================================

// Module: request_tagger
// PURPOSE
//  Front-end stage directly upstream of the in-order returner. Accepts read/write
//  requests, stamps each with a sequential per-type index (read/write tag), and
//  forwards them to the scheduler through a one-entry output register. Tracks
//  outstanding tags per type using retire pulses from the returner. Stalls
//  requests of a type whose tag space is exhausted, so no index is reused early.
// PARAMETERS
//  data_width         16  write-data width
//  addr_width         24  request address width
//  read_entries_log    6  log2 of read tag space (64 read tags)
//  write_entries_log   6  log2 of write tag space (64 write tags)
// PORTS
//  clk                input   1    clock
//  rst_n              input   1    synchronous reset, active low
//  req_valid          input   1    upstream request valid
//  req_ready          output  1    request accepted when req_valid && req_ready
//  req_type           input   1    read/write, types_def encoding
//  req_addr           input   addr_width   request address
//  req_data           input   data_width   write data (don't-care for reads)
//  out_valid          output  1    tagged request valid toward scheduler
//  out_ready          input   1    scheduler accepts when out_valid && out_ready
//  out_type           output  1    registered req_type
//  out_addr           output  addr_width   registered req_addr
//  out_data           output  data_width   registered req_data
//  out_index          output  max(read_entries_log,write_entries_log)  tag; zero-extended
//  read_retire        input   1    returner read_done pulse: oldest read tag freed
//  write_retire       input   1    returner write_done pulse: oldest write tag freed
//  read_outstanding   output  read_entries_log+1   reads tagged, not retired
//  write_outstanding  output  write_entries_log+1  writes tagged, not retired
//  tag_error          output  1    sticky: retire with zero outstanding of that type
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): out_valid=0, out_type/addr/data/index=0, both tag
//   counters=0, both outstanding=0, tag_error=0. Reset mid-transfer drops the
//   held request; no retire is recorded.
//  Credit: rd_full = read_outstanding==2**read_entries_log; wr_full likewise.
//  req_ready = (!out_valid || out_ready) && !(type_full for req_type); combinational
//   from current-cycle registers only (no bypass of same-cycle retire).
//  Accept: out register loads req fields, out_index <= current tag of that type,
//   that tag counter += 1 (wraps mod 2**entries_log), out_valid <= 1. Latency 1.
//  Drain: out_valid && out_ready && no accept -> out_valid <= 0. Accept and drain
//   in same cycle -> register reloads, out_valid stays 1 (full throughput).
//  Stall: out_valid && !out_ready -> all out_* held stable.
//  Outstanding (per type): +1 on accept of that type, -1 on retire of that type,
//   both same cycle -> unchanged. Retire at 0 -> count stays 0, tag_error <= 1.
//  Tags are issued strictly in order so the returner's counters match; index
//   counter is never reset except by rst_n.
//  Reads and writes share the output register; each type's credit is independent.
// TESTING
//  1. Reset, 3 reads then 2 writes with out_ready=1 -> out_index 0,1,2 (read), 0,1
//     (write), one per cycle after 1-cycle latency; read_outstanding=3, write=2.
//  2. 64 reads, no retire -> 65th read: req_ready=0; a write still accepted; one
//     read_retire -> next cycle read accepted with out_index 0 (wrap).
//  3. out_ready=0 for 5 cycles with out_valid=1 -> out_* stable, req_ready=0;
//     out_ready=1 with req_valid -> back-to-back transfer, no bubble.
//  4. Accept read and read_retire same cycle at read_outstanding=10 -> stays 10.
//  5. write_retire with write_outstanding=0 -> tag_error=1 sticky, count 0.
//  6. rst_n low while out_valid=1 and counters nonzero -> all outputs/counters 0
//     next cycle; next read gets out_index 0.

Source files
------------

// File: rtl/request_tagger.sv
// request_tagger: stamps read/write requests with per-type sequential tags
// and forwards them through a one-entry output register toward the scheduler.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_*                 upstream request (valid/ready, type, addr, data)
//   out_*                 tagged request toward scheduler (valid/ready, type,
//                         addr, data, index)
//   read_retire/write_retire  oldest tag of that type freed by the returner
//   read_outstanding/write_outstanding  tags issued and not yet retired
//   tag_error             sticky: retire seen with nothing outstanding
//
// req_type encoding: 0 = read, 1 = write.
module request_tagger #(
    parameter int data_width        = 16,
    parameter int addr_width        = 24,
    parameter int read_entries_log  = 6,
    parameter int write_entries_log = 6,
    localparam int idx_width = (read_entries_log > write_entries_log)
                             ? read_entries_log : write_entries_log
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_type,
    input  logic [addr_width-1:0]      req_addr,
    input  logic [data_width-1:0]      req_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_type,
    output logic [addr_width-1:0]      out_addr,
    output logic [data_width-1:0]      out_data,
    output logic [idx_width-1:0]       out_index,
    input  logic                       read_retire,
    input  logic                       write_retire,
    output logic [read_entries_log:0]  read_outstanding,
    output logic [write_entries_log:0] write_outstanding,
    output logic                       tag_error
);

    localparam logic type_write = 1'b1;
    localparam int   rd_cap     = 2 ** read_entries_log;
    localparam int   wr_cap     = 2 ** write_entries_log;

    logic [read_entries_log-1:0]  rd_tag;
    logic [write_entries_log-1:0] wr_tag;
    logic rd_full;
    logic wr_full;
    logic type_full;
    logic accept;
    logic rd_acc;
    logic wr_acc;

    assign rd_full = (read_outstanding == rd_cap[read_entries_log:0]);
    assign wr_full = (write_outstanding == wr_cap[write_entries_log:0]);
    assign type_full = (req_type == type_write) ? wr_full : rd_full;

    // Credit is judged on registered counts only; a retire in this cycle
    // frees the slot for the next cycle.
    assign req_ready = (!out_valid || out_ready) && !type_full;
    assign accept    = req_valid && req_ready;
    assign rd_acc    = accept && (req_type != type_write);
    assign wr_acc    = accept && (req_type == type_write);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid         <= 1'b0;
            out_type          <= 1'b0;
            out_addr          <= '0;
            out_data          <= '0;
            out_index         <= '0;
            rd_tag            <= '0;
            wr_tag            <= '0;
            read_outstanding  <= '0;
            write_outstanding <= '0;
            tag_error         <= 1'b0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_type  <= req_type;
                out_addr  <= req_addr;
                out_data  <= req_data;
                if (wr_acc) begin
                    out_index <= idx_width'(wr_tag);
                    wr_tag    <= wr_tag + 1'b1;
                end else begin
                    out_index <= idx_width'(rd_tag);
                    rd_tag    <= rd_tag + 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // A retire with nothing outstanding is a protocol error; the
            // count is left alone rather than underflowing.
            if (read_retire && read_outstanding == '0) begin
                tag_error <= 1'b1;
            end
            if (write_retire && write_outstanding == '0) begin
                tag_error <= 1'b1;
            end

            if (rd_acc && !read_retire) begin
                read_outstanding <= read_outstanding + 1'b1;
            end else if (!rd_acc && read_retire && read_outstanding != '0) begin
                read_outstanding <= read_outstanding - 1'b1;
            end

            if (wr_acc && !write_retire) begin
                write_outstanding <= write_outstanding + 1'b1;
            end else if (!wr_acc && write_retire && write_outstanding != '0) begin
                write_outstanding <= write_outstanding - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_request_tagger.sv
// tb_request_tagger: directed vector table plus hand-written sequences
// for credit exhaustion, stall, simultaneous retire, tag_error and reset.
module tb_request_tagger;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_type;
    logic [23:0] req_addr;
    logic [15:0] req_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_type;
    logic [23:0] out_addr;
    logic [15:0] out_data;
    logic [5:0]  out_index;
    logic        read_retire;
    logic        write_retire;
    logic [6:0]  read_outstanding;
    logic [6:0]  write_outstanding;
    logic        tag_error;

    int checks = 0;
    int errors = 0;

    request_tagger dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_type(req_type), .req_addr(req_addr), .req_data(req_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_type(out_type), .out_addr(out_addr), .out_data(out_data),
        .out_index(out_index),
        .read_retire(read_retire), .write_retire(write_retire),
        .read_outstanding(read_outstanding),
        .write_outstanding(write_outstanding),
        .tag_error(tag_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        t;
        logic [23:0] a;
        logic        ordy;
        logic        rr;
        logic        wr;
        logic        e_ov;
        logic        e_t;
        logic [5:0]  e_idx;
        logic [23:0] e_a;
        logic [6:0]  e_rd;
        logic [6:0]  e_wr;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid    = 1'b0;
        req_type     = 1'b0;
        req_addr     = '0;
        req_data     = '0;
        read_retire  = 1'b0;
        write_retire = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        out_ready = 1'b1;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic t, input logic [23:0] a);
        req_valid = 1'b1;
        req_type  = t;
        req_addr  = a;
        req_data  = a[15:0];
    endtask

    initial begin
        // v t addr ordy rr wr | ov t idx addr rd wr
        vecs[0] = '{1, 0, 24'h100, 1, 0, 0, 1, 0, 6'd0, 24'h100, 7'd1, 7'd0};
        vecs[1] = '{1, 0, 24'h101, 1, 0, 0, 1, 0, 6'd1, 24'h101, 7'd2, 7'd0};
        vecs[2] = '{1, 0, 24'h102, 1, 0, 0, 1, 0, 6'd2, 24'h102, 7'd3, 7'd0};
        vecs[3] = '{1, 1, 24'h200, 1, 0, 0, 1, 1, 6'd0, 24'h200, 7'd3, 7'd1};
        vecs[4] = '{1, 1, 24'h201, 1, 0, 0, 1, 1, 6'd1, 24'h201, 7'd3, 7'd2};
        vecs[5] = '{0, 0, 24'h0,   1, 0, 0, 0, 1, 6'd1, 24'h201, 7'd3, 7'd2};
        vecs[6] = '{0, 0, 24'h0,   1, 1, 0, 0, 1, 6'd1, 24'h201, 7'd2, 7'd2};
        vecs[7] = '{1, 0, 24'h103, 1, 1, 0, 1, 0, 6'd3, 24'h103, 7'd2, 7'd2};
        vecs[8] = '{0, 0, 24'h0,   1, 0, 1, 0, 0, 6'd3, 24'h103, 7'd2, 7'd1};

        do_reset();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_index", 32'(out_index), 0);
        check("rst_out_addr", 32'(out_addr), 0);
        check("rst_rd_out", 32'(read_outstanding), 0);
        check("rst_wr_out", 32'(write_outstanding), 0);
        check("rst_tag_error", 32'(tag_error), 0);
        check("rst_req_ready", 32'(req_ready), 1);

        // Test 1 + same-cycle accept/retire via vector table
        foreach (vecs[i]) begin
            req_valid    = vecs[i].v;
            req_type     = vecs[i].t;
            req_addr     = vecs[i].a;
            req_data     = vecs[i].a[15:0];
            out_ready    = vecs[i].ordy;
            read_retire  = vecs[i].rr;
            write_retire = vecs[i].wr;
            step();
            check($sformatf("v%0d_ov", i), 32'(out_valid), 32'(vecs[i].e_ov));
            check($sformatf("v%0d_type", i), 32'(out_type), 32'(vecs[i].e_t));
            check($sformatf("v%0d_idx", i), 32'(out_index), 32'(vecs[i].e_idx));
            check($sformatf("v%0d_addr", i), 32'(out_addr), 32'(vecs[i].e_a));
            check($sformatf("v%0d_data", i), 32'(out_data),
                  32'(vecs[i].e_a[15:0]));
            check($sformatf("v%0d_rd", i), 32'(read_outstanding),
                  32'(vecs[i].e_rd));
            check($sformatf("v%0d_wr", i), 32'(write_outstanding),
                  32'(vecs[i].e_wr));
        end
        idle();
        check("t1_no_error", 32'(tag_error), 0);

        // Test 2: read credit exhaustion and wrap
        do_reset();
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, 24'(i));
            step();
        end
        check("t2_idx63", 32'(out_index), 63);
        check("t2_rd64", 32'(read_outstanding), 64);
        drive(1'b0, 24'h777);
        #1;
        check("t2_rd_full_ready", 32'(req_ready), 0);
        step();
        check("t2_drain", 32'(out_valid), 0);
        drive(1'b1, 24'h888);
        #1;
        check("t2_wr_ready", 32'(req_ready), 1);
        step();
        check("t2_wr_ov", 32'(out_valid), 1);
        check("t2_wr_type", 32'(out_type), 1);
        check("t2_wr_idx", 32'(out_index), 0);
        drive(1'b0, 24'h999);
        read_retire = 1'b1;
        #1;
        check("t2_no_bypass", 32'(req_ready), 0);
        step();
        read_retire = 1'b0;
        check("t2_rd63", 32'(read_outstanding), 63);
        check("t2_rd_ready", 32'(req_ready), 1);
        step();
        check("t2_wrap_ov", 32'(out_valid), 1);
        check("t2_wrap_type", 32'(out_type), 0);
        check("t2_wrap_idx", 32'(out_index), 0);
        check("t2_wrap_addr", 32'(out_addr), 32'h999);
        check("t2_rd64b", 32'(read_outstanding), 64);
        idle();

        // Test 3: stall then back-to-back
        do_reset();
        out_ready = 1'b0;
        drive(1'b0, 24'hA00);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 24'hA10 + 24'(i));
            #1;
            check("t3_stall_ready", 32'(req_ready), 0);
            step();
            check("t3_stall_ov", 32'(out_valid), 1);
            check("t3_stall_addr", 32'(out_addr), 32'hA00);
            check("t3_stall_idx", 32'(out_index), 0);
        end
        out_ready = 1'b1;
        drive(1'b0, 24'hB00);
        #1;
        check("t3_resume_ready", 32'(req_ready), 1);
        step();
        check("t3_b2b1_ov", 32'(out_valid), 1);
        check("t3_b2b1_addr", 32'(out_addr), 32'hB00);
        check("t3_b2b1_idx", 32'(out_index), 1);
        drive(1'b0, 24'hB01);
        step();
        check("t3_b2b2_addr", 32'(out_addr), 32'hB01);
        check("t3_b2b2_idx", 32'(out_index), 2);
        idle();

        // Test 4: accept and retire together at 10 outstanding
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 24'(i));
            step();
        end
        check("t4_rd10", 32'(read_outstanding), 10);
        drive(1'b0, 24'hC00);
        read_retire = 1'b1;
        step();
        idle();
        check("t4_rd_still10", 32'(read_outstanding), 10);
        check("t4_idx10", 32'(out_index), 10);

        // Test 5: retire underflow is sticky
        do_reset();
        write_retire = 1'b1;
        step();
        write_retire = 1'b0;
        check("t5_err", 32'(tag_error), 1);
        check("t5_wr0", 32'(write_outstanding), 0);
        step();
        check("t5_err_sticky", 32'(tag_error), 1);

        // Test 6: reset while holding a request
        out_ready = 1'b0;
        drive(1'b0, 24'hD00);
        step();
        drive(1'b1, 24'hD01);
        step();
        check("t6_pre_ov", 32'(out_valid), 1);
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("t6_ov", 32'(out_valid), 0);
        check("t6_addr", 32'(out_addr), 0);
        check("t6_idx", 32'(out_index), 0);
        check("t6_rd", 32'(read_outstanding), 0);
        check("t6_wr", 32'(write_outstanding), 0);
        check("t6_err", 32'(tag_error), 0);
        out_ready = 1'b1;
        drive(1'b0, 24'hD02);
        step();
        idle();
        check("t6_first_idx", 32'(out_index), 0);
        check("t6_first_ov", 32'(out_valid), 1);
        check("t6_rd1", 32'(read_outstanding), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
